// File: rtl/aap_fetch_pkg.sv
// Shared types and constants for the AAP instruction fetch sequencer.
package aap_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        HOLD     = 2'd3
    } fetch_state_t;

    localparam int PC_W_DEFAULT    = 24;
    localparam int DIV_MAX_DEFAULT = 217;
    localparam int INSN32_FLAG_BIT = 15;

    // Bit 15 of the first halfword marks a 32-bit instruction.
    function automatic logic is_insn32(input logic [15:0] halfword);
        return halfword[INSN32_FLAG_BIT];
    endfunction

endpackage

// File: rtl/aap_tick_divider.sv
// Free-running 0..DIV_MAX counter producing a single-cycle tick at terminal count.
module aap_tick_divider
    import aap_fetch_pkg::*;
#(
    parameter int DIV_MAX = DIV_MAX_DEFAULT
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(DIV_MAX));

    always_ff @(posedge CLOCK_50) begin
        if (reset || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aap_fetch_sequencer.sv
// Fetches 16/32-bit AAP instructions halfword by halfword and hands them to the decoder.
// Define FETCH_THROTTLE_EN to limit fetch starts to one per DIV_MAX+1 cycles.
module aap_fetch_sequencer
    import aap_fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int DIV_MAX = DIV_MAX_DEFAULT
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            insn_valid,
    input  logic            insn_ready,
    output logic [31:0]     insn_word,
    output logic            insn_is32,
    output logic [PC_W-1:0] insn_pc,
    input  logic            branch_valid,
    input  logic [PC_W-1:0] branch_target,
    output logic [1:0]      state
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     word_q, word_d;
    logic            is32_q, is32_d;
    logic            tick;

`ifdef FETCH_THROTTLE_EN
    aap_tick_divider #(
        .DIV_MAX (DIV_MAX)
    ) u_tick_divider (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick     (tick)
    );
`else
    logic unused_div_max;
    assign unused_div_max = (DIV_MAX > 0);
    assign tick = 1'b1;
`endif

    assign state      = state_q;
    assign imem_req   = (state_q == FETCH_LO) || (state_q == FETCH_HI);
    assign imem_addr  = (state_q == FETCH_HI) ? pc_q + PC_W'(1) : pc_q;
    assign insn_valid = (state_q == HOLD);
    assign insn_word  = word_q;
    assign insn_is32  = is32_q;
    assign insn_pc    = pc_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            word_q  <= '0;
            is32_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            word_q  <= word_d;
            is32_q  <= is32_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        word_d  = word_q;
        is32_d  = is32_q;

        case (state_q)
            IDLE: begin
                if (run && tick) begin
                    state_d = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (imem_ack) begin
                    word_d[15:0] = imem_rdata;
                    if (is_insn32(imem_rdata)) begin
                        state_d = FETCH_HI;
                    end else begin
                        word_d[31:16] = '0;
                        is32_d        = 1'b0;
                        state_d       = HOLD;
                    end
                end
            end
            FETCH_HI: begin
                if (imem_ack) begin
                    word_d[31:16] = imem_rdata;
                    is32_d        = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (insn_ready) begin
                    pc_d = pc_q + (is32_q ? PC_W'(2) : PC_W'(1));
`ifdef FETCH_THROTTLE_EN
                    state_d = IDLE;
`else
                    state_d = run ? FETCH_LO : IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // A redirect overrides everything above, including a same-cycle ack or increment.
        if (branch_valid) begin
            pc_d    = branch_target;
            word_d  = word_q;
            is32_d  = is32_q;
            state_d = run ? FETCH_LO : IDLE;
        end
    end

endmodule

// File: tb/tb_aap_fetch_sequencer.sv
// Directed self-checking bench for aap_fetch_sequencer with an instruction scoreboard.
// Builds with or without FETCH_THROTTLE_EN; each build runs the matching sequence.
module tb_aap_fetch_sequencer;
    import aap_fetch_pkg::*;

    localparam int PC_W = 24;

    logic            CLOCK_50 = 1'b0;
    logic            reset;
    logic            run;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_rdata;
    logic            insn_valid;
    logic            insn_ready;
    logic [31:0]     insn_word;
    logic            insn_is32;
    logic [PC_W-1:0] insn_pc;
    logic            branch_valid;
    logic [PC_W-1:0] branch_target;
    logic [1:0]      state;

    typedef struct {
        logic [31:0]     word;
        logic            is32;
        logic [PC_W-1:0] pc;
    } insn_exp_t;

    insn_exp_t   sb[$];
    logic [15:0] mem [logic [PC_W-1:0]];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          t_entry [3];

    aap_fetch_sequencer #(
        .PC_W    (PC_W),
        .DIV_MAX (217)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .run           (run),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .insn_valid    (insn_valid),
        .insn_ready    (insn_ready),
        .insn_word     (insn_word),
        .insn_is32     (insn_is32),
        .insn_pc       (insn_pc),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .state         (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_output(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; the zero-wait memory acks in the same cycle as the request.
    task automatic step();
        @(posedge CLOCK_50);
        #1;
        cyc++;
        imem_ack   = imem_req;
        imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 16'h0000;
    endtask

    task automatic apply_stimulus(input logic r, input logic rdy, input logic br, input logic [PC_W-1:0] tgt);
        run           = r;
        insn_ready    = rdy;
        branch_valid  = br;
        branch_target = tgt;
    endtask

    task automatic expect_insn(input logic [31:0] w, input logic is32, input logic [PC_W-1:0] pc);
        insn_exp_t e;
        e.word = w;
        e.is32 = is32;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    task automatic expect_fetch(input string tag, input logic [1:0] st, input logic [PC_W-1:0] addr);
        check_output(tag, {state, imem_req, imem_addr}, {st, 1'b1, addr});
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== target && n < budget) begin
            step();
            n++;
        end
        check_output(tag, state, target);
    endtask

    // Scoreboard: every completed handshake must match the oldest expected instruction.
    always @(negedge CLOCK_50) begin
        insn_exp_t e;
        if (!reset && insn_valid && insn_ready) begin
            check_output("sb_nonempty", 96'(sb.size() != 0), 96'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_output("sb_insn", {insn_word, insn_is32, insn_pc}, {e.word, e.is32, e.pc});
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        step();
        step();
        check_output("reset_state", {state, imem_req, insn_valid, insn_is32, imem_addr, insn_pc, insn_word}, '0);

        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h8001;
        step();
        check_output("ack_after_reset", {state, insn_word}, '0);

`ifndef FETCH_THROTTLE_EN
        mem[24'h000000] = 16'h1234;
        expect_insn(32'h0000_1234, 1'b0, 24'h000000);
        expect_insn(32'h0000_0000, 1'b0, 24'h000001);
        apply_stimulus(1'b1, 1'b1, 1'b0, '0);
        step();
        expect_fetch("lo_addr0", FETCH_LO, 24'h000000);
        step();
        check_output("valid_latency", {state, insn_valid}, {HOLD, 1'b1});
        step();
        expect_fetch("next_addr1", FETCH_LO, 24'h000001);
        run = 1'b0;
        step();
        step();
        check_output("idle_after_run_low", {state, insn_valid, imem_req, insn_pc}, {IDLE, 1'b0, 1'b0, 24'd2});

        mem[24'h000004] = 16'h8001;
        mem[24'h000005] = 16'hBEEF;
        mem[24'h000006] = 16'h4321;
        expect_insn(32'hBEEF_8001, 1'b1, 24'h000004);
        expect_insn(32'h0000_4321, 1'b0, 24'h000006);
        apply_stimulus(1'b1, 1'b1, 1'b1, 24'h000004);
        step();
        branch_valid = 1'b0;
        expect_fetch("lo_addr4", FETCH_LO, 24'h000004);
        step();
        expect_fetch("hi_addr5", FETCH_HI, 24'h000005);
        step();
        check_output("hold32", {state, insn_is32}, {HOLD, 1'b1});
        step();
        expect_fetch("after32_addr6", FETCH_LO, 24'h000006);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_output("hold_stable", {state, insn_valid, imem_req, insn_is32, insn_word, insn_pc},
                         {HOLD, 1'b1, 1'b0, 1'b0, 32'h0000_4321, 24'h000006});
        end
        insn_ready = 1'b1;
        step();
        check_output("idle_pc7", {state, insn_pc}, {IDLE, 24'h000007});

        mem[24'h000007] = 16'h9000;
        mem[24'h000008] = 16'h5555;
        mem[24'h000100] = 16'h0042;
        expect_insn(32'h0000_0042, 1'b0, 24'h000100);
        run = 1'b1;
        step();
        expect_fetch("lo_addr7", FETCH_LO, 24'h000007);
        step();
        expect_fetch("hi_addr8", FETCH_HI, 24'h000008);
        apply_stimulus(1'b1, 1'b1, 1'b1, 24'h000100);
        step();
        branch_valid = 1'b0;
        expect_fetch("redirect_hi", FETCH_LO, 24'h000100);
        run = 1'b0;
        step();
        step();
        check_output("idle_pc101", {state, insn_pc}, {IDLE, 24'h000101});

        mem[24'h000101] = 16'h0777;
        expect_insn(32'h0000_0777, 1'b0, 24'h000101);
        expect_insn(32'h0000_0042, 1'b0, 24'h000100);
        run = 1'b1;
        step();
        expect_fetch("lo_addr101", FETCH_LO, 24'h000101);
        step();
        apply_stimulus(1'b1, 1'b1, 1'b1, 24'h000100);
        step();
        branch_valid = 1'b0;
        expect_fetch("redirect_hs", FETCH_LO, 24'h000100);
        run = 1'b0;
        step();
        step();
        check_output("idle_after_hs", {state, insn_pc}, {IDLE, 24'h000101});

        mem[24'hFFFFFF] = 16'h8123;
        expect_insn(32'h1234_8123, 1'b1, 24'hFFFFFF);
        expect_insn(32'h0000_0000, 1'b0, 24'h000001);
        apply_stimulus(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        step();
        branch_valid = 1'b0;
        expect_fetch("lo_wrap", FETCH_LO, 24'hFFFFFF);
        step();
        expect_fetch("hi_wrap", FETCH_HI, 24'h000000);
        step();
        step();
        expect_fetch("after_wrap_pc1", FETCH_LO, 24'h000001);
        run = 1'b0;
        step();
        step();
        check_output("idle_pc2", {state, insn_pc}, {IDLE, 24'h000002});

        mem[24'h000020] = 16'h8000;
        apply_stimulus(1'b1, 1'b1, 1'b1, 24'h000020);
        step();
        branch_valid = 1'b0;
        step();
        check_output("in_fetch_hi", state, FETCH_HI);
        reset = 1'b1;
        step();
        check_output("reset_mid_hi", {state, imem_req, insn_valid, insn_is32, imem_addr, insn_pc, insn_word}, '0);
        reset = 1'b0;
        run   = 1'b0;
        step();
        check_output("idle_after_reset", state, IDLE);
`else
        for (int k = 0; k < 3; k++) begin
            expect_insn(32'h0000_0000, 1'b0, PC_W'(k));
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            wait_state(FETCH_LO, 400, "throttle_entry");
            t_entry[k] = cyc;
            if (k == 2) begin
                run = 1'b0;
            end
            step();
        end
        check_output("throttle_gap1", 96'(t_entry[1] - t_entry[0]), 96'd218);
        check_output("throttle_gap2", 96'(t_entry[2] - t_entry[1]), 96'd218);
        wait_state(IDLE, 10, "throttle_idle");
`endif

        step();
        step();
        check_output("sb_drained", 96'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
